// File: rtl/imem_loader.sv
// imem_loader: streams bytes into 32-bit little-endian instruction words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        len_err,
    output logic        csum_ok
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;

    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    logic [2:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] count;
    logic [31:0] len_eff;
    logic [31:0] len_in;
    logic        clamp;
    logic        last_word;
    logic        can_start;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;
    logic [31:0] csum_rx;
    logic        csum_ok_r;
`endif

    assign len_in    = {16'd0, len_words};
    assign clamp     = len_in > DEPTH;
    assign last_word = (count + 32'd1) >= len_eff;
    assign can_start = start && (state == S_IDLE || state == S_DONE);

    assign byte_ready = (state == S_RECV) || (state == S_CSUM);
    assign we         = (state == S_WRITE);
    assign busy       = (state == S_RECV) || (state == S_WRITE);
    assign done       = (state == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign csum_ok = done && csum_ok_r;
`else
    assign csum_ok = done;
`endif

    // Load sequencer: byte assembly, word writes and address stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_idx <= 2'd0;
            count    <= 32'd0;
            len_eff  <= 32'd0;
            waddr    <= BASE_ADDR;
            wdata    <= 32'd0;
            len_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc  <= 32'd0;
            csum_rx   <= 32'd0;
            csum_ok_r <= 1'b0;
`endif
        end else if (can_start) begin
            len_eff  <= clamp ? DEPTH : len_in;
            len_err  <= clamp;
            byte_idx <= 2'd0;
            count    <= 32'd0;
            waddr    <= BASE_ADDR;
            wdata    <= 32'd0;
            state    <= (len_in == 32'd0) ? S_DONE : S_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc  <= 32'd0;
            csum_rx   <= 32'd0;
            csum_ok_r <= (len_in == 32'd0);
`endif
        end else begin
            case (state)
                S_RECV: begin
                    if (byte_valid) begin
                        wdata[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    count <= count + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_acc <= csum_acc ^ wdata;
`endif
                    // hold waddr on the final word so it never runs past the array
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        waddr <= waddr + 32'd4;
                        state <= S_RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (byte_valid) begin
                        csum_rx[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            csum_ok_r <= ({byte_in, csum_rx[23:0]} == csum_acc);
                            state     <= S_DONE;
                        end
                    end
                end
`endif
                S_IDLE, S_DONE: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven checks of the byte-stream loader.
// Default build; checksum sequences compile in with IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        len_err;
    logic        csum_ok;

    int nchk = 0;
    int nerr = 0;
    int vio  = 0;
    logic [63:0] wq[$];

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .len_words(len_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .len_err(len_err), .csum_ok(csum_ok)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (we) wq.push_back({waddr, wdata});
        if (waddr > 32'h3FC) vio++;
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;
    vec_t vec[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] get(input int i);
        if (i < wq.size()) return wq[i];
        return 64'hEEEEEEEE_EEEEEEEE;
    endfunction

    task automatic start_load(input logic [15:0] len);
        start = 1'b1;
        len_words = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready) begin
            nchk++;
            nerr++;
            $display("FAIL byte_ready timeout: got 0, expected 1");
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic finish_csum(input logic [31:0] x);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(x);
`else
        x = x;
`endif
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " done"}, 32'(done), 32'd1);
    endtask

    logic [31:0] prog[5];
    logic [31:0] x;
    logic [31:0] w;

    initial begin
        vec[0] = '{8'h13, 8'h01, 8'h01, 8'hfe, 32'hfe010113};
        vec[1] = '{8'h23, 8'h2e, 8'h81, 8'h00, 32'h00812e23};
        vec[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vec[3] = '{8'hff, 8'hff, 8'hff, 8'hff, 32'hffffffff};
        vec[4] = '{8'h01, 8'h23, 8'h45, 8'h67, 32'h67452301};
        prog = '{32'hfe010113, 32'h00812e23, 32'h02010413,
                 32'h0000b7b7, 32'hbcd78793};

        rst = 1'b1; start = 1'b0; len_words = '0;
        byte_in = '0; byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst byte_ready", 32'(byte_ready), 32'd0);
        chk("rst we", 32'(we), 32'd0);
        chk("rst waddr", waddr, 32'd0);
        chk("rst wdata", wdata, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst len_err", 32'(len_err), 32'd0);
        chk("rst csum_ok", 32'(csum_ok), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single-word loads from the vector table, each restarted from DONE
        for (int i = 0; i < 5; i++) begin
            wq.delete();
            start_load(16'd1);
            chk("vec busy", 32'(busy), 32'd1);
            chk("vec csum_ok busy", 32'(csum_ok), 32'd0);
            send_byte(vec[i].b0);
            send_byte(vec[i].b1);
            send_byte(vec[i].b2);
            send_byte(vec[i].b3);
            finish_csum(vec[i].exp);
            wait_done("vec");
            chk("vec nwrites", wq.size(), 32'd1);
            chk("vec addr", get(0)[63:32], 32'h0);
            chk("vec data", get(0)[31:0], vec[i].exp);
            chk("vec csum_ok", 32'(csum_ok), 32'd1);
            chk("vec busy end", 32'(busy), 32'd0);
        end

        // five-word program, with a start pulse while busy that must be ignored
        wq.delete();
        start_load(16'd5);
        x = 32'd0;
        for (int i = 0; i < 5; i++) begin
            send_word(prog[i]);
            x = x ^ prog[i];
            if (i == 1) start_load(16'd1);
        end
        finish_csum(x);
        wait_done("prog");
        chk("prog nwrites", wq.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("prog addr", get(i)[63:32], 32'(i * 4));
            chk("prog data", get(i)[31:0], prog[i]);
        end

        // stall between bytes 2 and 3
        wq.delete();
        start_load(16'd1);
        send_byte(8'h13);
        send_byte(8'h01);
        for (int k = 0; k < 3; k++) begin
            chk("stall we", 32'(we), 32'd0);
            chk("stall ready", 32'(byte_ready), 32'd1);
            chk("stall busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        send_byte(8'h01);
        send_byte(8'hfe);
        finish_csum(32'hfe010113);
        wait_done("stall");
        chk("stall nwrites", wq.size(), 32'd1);
        chk("stall addr", get(0)[63:32], 32'h0);
        chk("stall data", get(0)[31:0], 32'hfe010113);

        // zero length
        wq.delete();
        start_load(16'd0);
        chk("len0 done", 32'(done), 32'd1);
        chk("len0 busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("len0 nwrites", wq.size(), 32'd0);

        // oversize length clamps to 256 words
        wq.delete();
        start_load(16'd300);
        chk("clamp len_err", 32'(len_err), 32'd1);
        x = 32'd0;
        for (int i = 0; i < 256; i++) begin
            w = 32'h10000000 + 32'(i) * 32'd3;
            x = x ^ w;
            send_word(w);
        end
        finish_csum(x);
        wait_done("clamp");
        chk("clamp nwrites", wq.size(), 32'd256);
        chk("clamp first addr", get(0)[63:32], 32'h0);
        chk("clamp last addr", get(255)[63:32], 32'h3FC);
        chk("clamp last data", get(255)[31:0], 32'h100002FD);
        chk("clamp waddr held", waddr, 32'h3FC);
        chk("clamp len_err end", 32'(len_err), 32'd1);

        // reset out of DONE with len_err set
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2 len_err", 32'(len_err), 32'd0);
        chk("rst2 done", 32'(done), 32'd0);
        chk("rst2 waddr", waddr, 32'd0);

        // reset after two bytes discards the partial word
        wq.delete();
        start_load(16'd1);
        chk("next start len_err", 32'(len_err), 32'd0);
        send_byte(8'h13);
        send_byte(8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ready", 32'(byte_ready), 32'd0);
        chk("midrst wdata", wdata, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst nwrites", wq.size(), 32'd0);
        start_load(16'd1);
        send_word(32'h00004137);
        finish_csum(32'h00004137);
        wait_done("midrst");
        chk("midrst reload n", wq.size(), 32'd1);
        chk("midrst reload addr", get(0)[63:32], 32'h0);
        chk("midrst reload data", get(0)[31:0], 32'h00004137);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wq.delete();
        start_load(16'd2);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h3);
        wait_done("csum good");
        chk("csum good ok", 32'(csum_ok), 32'd1);
        chk("csum good n", wq.size(), 32'd2);
        wq.delete();
        start_load(16'd2);
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h4);
        wait_done("csum bad");
        chk("csum bad ok", 32'(csum_ok), 32'd0);
        chk("csum bad n", wq.size(), 32'd2);
`endif

        chk("waddr bound", vio, 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
